// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator and its consumer
//   vga_pix_en      consumer -> generator  pixel advance enable
//   vga_hsync       generator -> consumer  horizontal sync
//   vga_vsync       generator -> consumer  vertical sync
//   vga_valid       generator -> consumer  active-area flag
//   vga_h_cnt       generator -> consumer  pixel column
//   vga_v_cnt       generator -> consumer  line number
//   vga_line_start  generator -> consumer  line start strobe
//   vga_frame_start generator -> consumer  frame start strobe
interface vga_timing_gen_if #(
   parameter int H_CNT_W = 12,
   parameter int V_CNT_W = 11
);
   logic               vga_pix_en;
   logic               vga_hsync;
   logic               vga_vsync;
   logic               vga_valid;
   logic [H_CNT_W-1:0] vga_h_cnt;
   logic [V_CNT_W-1:0] vga_v_cnt;
   logic               vga_line_start;
   logic               vga_frame_start;
   modport master (
      input  vga_pix_en,
      output vga_hsync, vga_vsync, vga_valid, vga_h_cnt, vga_v_cnt, vga_line_start, vga_frame_start
   );
   modport slave (
      output vga_pix_en,
      input  vga_hsync, vga_vsync, vga_valid, vga_h_cnt, vga_v_cnt, vga_line_start, vga_frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator (counts, syncs, valid, line/frame strobes)
//   vga_pclk  in   pixel clock
//   vga_rst   in   synchronous reset, active-high
//   bus       vga_timing_gen_if.master: pix_en in; hsync, vsync, valid, h_cnt, v_cnt,
//             line_start, frame_start out
// Optional feature: define VGA_TIMING_DELAY_EN to pass sync/valid/strobes through DELAY extra
// pix_en-gated stages; counts are not delayed and therefore lead those outputs by DELAY pixels.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int H_CNT_W  = 12,
   parameter int V_CNT_W  = 11,
   parameter int DELAY    = 2
) (
   input logic              vga_pclk,
   input logic              vga_rst,
   vga_timing_gen_if.master bus
);
   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(HT - 1);
   localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(VT - 1);
   localparam logic [H_CNT_W-1:0] H_ACT  = H_CNT_W'(H_ACTIVE);
   localparam logic [V_CNT_W-1:0] V_ACT  = V_CNT_W'(V_ACTIVE);
   localparam logic [H_CNT_W-1:0] HS_BEG = H_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_CNT_W-1:0] HS_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_CNT_W-1:0] VS_BEG = V_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [V_CNT_W-1:0] VS_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   // Timing bundle bit order: {hsync, vsync, valid, line_start, frame_start}
   localparam logic [4:0] INACT = {~H_POL, ~V_POL, 3'b000};
   logic [H_CNT_W-1:0] r_h, r_h_cnt;
   logic [V_CNT_W-1:0] r_v, r_v_cnt;
   logic [4:0]         r_s0;
   logic [4:0]         w_cur;
   logic [4:0]         w_out;
   logic               r_adv;
   logic               w_h_wrap;
   logic               w_v_wrap;
   assign w_h_wrap = r_h == H_LAST;
   assign w_v_wrap = r_v == V_LAST;
   assign w_cur = {(r_h >= HS_BEG && r_h < HS_END) ? H_POL : ~H_POL,
                   (r_v >= VS_BEG && r_v < VS_END) ? V_POL : ~V_POL,
                   r_h < H_ACT && r_v < V_ACT,
                   r_h == '0,
                   r_h == '0 && r_v == '0};
   always_ff @(posedge vga_pclk) begin
      if (vga_rst) begin
         r_h     <= '0;
         r_v     <= '0;
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         r_s0    <= INACT;
         r_adv   <= 1'b0;
      end else begin
         r_adv <= bus.vga_pix_en;
         if (bus.vga_pix_en) begin
            r_h     <= w_h_wrap ? '0 : r_h + 1'b1;
            r_v     <= w_h_wrap ? (w_v_wrap ? '0 : r_v + 1'b1) : r_v;
            r_h_cnt <= r_h;
            r_v_cnt <= r_v;
            r_s0    <= w_cur;
         end
      end
   end
`ifdef VGA_TIMING_DELAY_EN
   logic [4:0] r_dl [DELAY];
   always_ff @(posedge vga_pclk) begin
      if (vga_rst) begin
         for (int i = 0; i < DELAY; i++) r_dl[i] <= INACT;
      end else if (bus.vga_pix_en) begin
         r_dl[0] <= r_s0;
         for (int i = 1; i < DELAY; i++) r_dl[i] <= r_dl[i-1];
      end
   end
   assign w_out = r_dl[DELAY-1];
`else
   assign w_out = r_s0;
`endif
   // Strobe bits hold with the stage on idle cycles; r_adv limits them to the clock after an advance
   assign bus.vga_hsync       = w_out[4];
   assign bus.vga_vsync       = w_out[3];
   assign bus.vga_valid       = w_out[2];
   assign bus.vga_line_start  = w_out[1] & r_adv;
   assign bus.vga_frame_start = w_out[0] & r_adv;
   assign bus.vga_h_cnt       = r_h_cnt;
   assign bus.vga_v_cnt       = r_v_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen (default 640x480 and a 16x8 raster)
module tb_vga_timing_gen;
   localparam int LAT =
`ifdef VGA_TIMING_DELAY_EN
      2;
`else
      0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   vga_timing_gen_if #(.H_CNT_W(12), .V_CNT_W(11)) ia ();
   vga_timing_gen_if #(.H_CNT_W(12), .V_CNT_W(11)) ib ();
   vga_timing_gen dut_a (.vga_pclk(clk), .vga_rst(rst), .bus(ia));
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1)
   ) dut_b (.vga_pclk(clk), .vga_rst(rst), .bus(ib));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   initial begin
      int a_val, a_hs_lo, a_hs_first, a_hs_last, a_vs_lo, trk, hold_err, prev_h;
      int b_vs, b_hs, b_val, b_vs_first, b_hs_first, fs_extra;
      int ls_at[$];
      int fs_at[$];
      a_val = 0; a_hs_lo = 0; a_hs_first = -1; a_hs_last = -1; a_vs_lo = 0; trk = 0; hold_err = 0;
      b_vs = 0; b_hs = 0; b_val = 0; b_vs_first = -1; b_hs_first = -1; fs_extra = 0;
      ia.vga_pix_en = 1'b0;
      ib.vga_pix_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_h", 32'(ia.vga_h_cnt), 0);
      chk("rst_a_v", 32'(ia.vga_v_cnt), 0);
      chk("rst_a_hsync", 32'(ia.vga_hsync), 1);
      chk("rst_a_vsync", 32'(ia.vga_vsync), 1);
      chk("rst_a_valid", 32'(ia.vga_valid), 0);
      chk("rst_a_ls", 32'(ia.vga_line_start), 0);
      chk("rst_a_fs", 32'(ia.vga_frame_start), 0);
      chk("rst_b_hsync", 32'(ib.vga_hsync), 0);
      chk("rst_b_vsync", 32'(ib.vga_vsync), 0);
      rst = 1'b0;
      ia.vga_pix_en = 1'b1;
      for (int c = 0; c < 1700; c++) begin
         @(negedge clk);
         if (int'(ia.vga_h_cnt) != c % 800 || int'(ia.vga_v_cnt) != c / 800) trk++;
         if (c < 1600 && ia.vga_valid) a_val++;
         if (c < 800 && !ia.vga_hsync) begin
            a_hs_lo++;
            if (a_hs_first < 0) a_hs_first = c;
            a_hs_last = c;
         end
         if (!ia.vga_vsync) a_vs_lo++;
         if (ia.vga_line_start) ls_at.push_back(c);
         if (ia.vga_frame_start) fs_at.push_back(c);
      end
      chk("a_count_track", 32'(trk), 0);
      chk("a_valid_2lines", 32'(a_val), 1280);
      chk("a_hsync_width", 32'(a_hs_lo), 96);
      chk("a_hsync_first", 32'(a_hs_first), 32'(656 + LAT));
      chk("a_hsync_last", 32'(a_hs_last), 32'(751 + LAT));
      chk("a_vsync_idle", 32'(a_vs_lo), 0);
      chk("a_ls_count", 32'(ls_at.size()), 3);
      chk("a_ls_first", 32'(ls_at.size() > 0 ? ls_at[0] : -1), 32'(LAT));
      chk("a_ls_period", 32'(ls_at.size() > 1 ? ls_at[1] - ls_at[0] : -1), 800);
      chk("a_fs_count", 32'(fs_at.size()), 1);
      chk("a_fs_first", 32'(fs_at.size() > 0 ? fs_at[0] : -1), 32'(LAT));
      prev_h = int'(ia.vga_h_cnt);
      ls_at.delete();
      for (int k = 0; k < 4000; k++) begin
         ia.vga_pix_en = (k % 2 == 0);
         @(negedge clk);
         if (int'(ia.vga_h_cnt) != (ia.vga_pix_en ? (prev_h + 1) % 800 : prev_h)) hold_err++;
         if (ia.vga_line_start) begin
            ls_at.push_back(k);
            if (!ia.vga_pix_en) hold_err++;
         end
         prev_h = int'(ia.vga_h_cnt);
      end
      ia.vga_pix_en = 1'b0;
      chk("a_toggle_hold", 32'(hold_err), 0);
      chk("a_toggle_ls_count", 32'(ls_at.size()), 2);
      chk("a_toggle_ls_period", 32'(ls_at.size() > 1 ? ls_at[1] - ls_at[0] : -1), 1600);
      trk = 0;
      fs_at.delete();
      ib.vga_pix_en = 1'b1;
      for (int c = 0; c < 309; c++) begin
         @(negedge clk);
         if (int'(ib.vga_h_cnt) != c % 16 || int'(ib.vga_v_cnt) != (c / 16) % 8) trk++;
         if (ib.vga_frame_start) fs_at.push_back(c);
         if (c >= 128 && c < 256) begin
            if (ib.vga_vsync) begin
               b_vs++;
               if (b_vs_first < 0) b_vs_first = c;
            end
            if (ib.vga_hsync) begin
               b_hs++;
               if (b_hs_first < 0) b_hs_first = c;
            end
            if (ib.vga_valid) b_val++;
         end
      end
      chk("b_count_track", 32'(trk), 0);
      chk("b_fs_count", 32'(fs_at.size()), 3);
      chk("b_fs_first", 32'(fs_at.size() > 0 ? fs_at[0] : -1), 32'(LAT));
      chk("b_fs_period", 32'(fs_at.size() > 1 ? fs_at[1] - fs_at[0] : -1), 128);
      chk("b_vsync_width", 32'(b_vs), 32);
      chk("b_hsync_width", 32'(b_hs), 24);
      chk("b_valid_frame", 32'(b_val), 32);
      chk("b_vsync_first", 32'(b_vs_first), 32'(208 + LAT));
      chk("b_hsync_first", 32'(b_hs_first), 32'(138 + LAT));
      rst = 1'b1;
      @(negedge clk);
      chk("b_midrst_h", 32'(ib.vga_h_cnt), 0);
      chk("b_midrst_v", 32'(ib.vga_v_cnt), 0);
      chk("b_midrst_valid", 32'(ib.vga_valid), 0);
      chk("b_midrst_hsync", 32'(ib.vga_hsync), 0);
      chk("b_midrst_vsync", 32'(ib.vga_vsync), 0);
      chk("b_midrst_ls", 32'(ib.vga_line_start), 0);
      chk("b_midrst_fs", 32'(ib.vga_frame_start), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         if (r == 0) begin
            chk("b_post_h", 32'(ib.vga_h_cnt), 0);
            chk("b_post_v", 32'(ib.vga_v_cnt), 0);
         end
         if (r == LAT) begin
            chk("b_post_fs", 32'(ib.vga_frame_start), 1);
            chk("b_post_ls", 32'(ib.vga_line_start), 1);
         end else if (ib.vga_frame_start) fs_extra++;
      end
      chk("b_post_fs_extra", 32'(fs_extra), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
